// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - handshaked MIPS ALU with iterative unsigned multiply and divide
// Single-cycle ops register their result on acceptance; MUL/DIVU share one shift/add datapath.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Zero,
    output logic             Overflow,
    output logic             DivByZero
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   reshi_q, reshi_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH-1:0]   add_res, sub_res, single_res;
    logic               single_ovf;
    logic [WIDTH:0]     add_a;
    logic [WIDTH+1:0]   add_b, sum;
    logic [WIDTH-1:0]   iter_hi, iter_lo;

    always_comb begin
        add_res    = SrcA + SrcB;
        sub_res    = SrcA - SrcB;
        single_res = '0;
        single_ovf = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                single_res = add_res;
                single_ovf = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (add_res[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_SUB: begin
                single_res = sub_res;
                single_ovf = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (sub_res[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_AND:  single_res = SrcA & SrcB;
            OP_OR:   single_res = SrcA | SrcB;
            OP_NOR:  single_res = ~(SrcA | SrcB);
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
            default: single_res = '0;
        endcase
    end

    // MUL: {hi,lo} shifts right, adding the multiplicand into hi when lo[0] is set.
    // DIVU: {hi,lo} shifts left, trial-subtracting the divisor; sum[WIDTH+1] is the borrow.
    always_comb begin
        if (is_div_q) begin
            add_a = {hi_q, lo_q[WIDTH-1]};
            add_b = ~{2'b00, opb_q};
        end else begin
            add_a = {1'b0, hi_q};
            add_b = lo_q[0] ? {2'b00, opb_q} : '0;
        end
        sum = {1'b0, add_a} + add_b + {{(WIDTH+1){1'b0}}, is_div_q};
        if (is_div_q) begin
            iter_hi = sum[WIDTH+1] ? add_a[WIDTH-1:0] : sum[WIDTH-1:0];
            iter_lo = {lo_q[WIDTH-2:0], ~sum[WIDTH+1]};
        end else begin
            iter_hi = sum[WIDTH:1];
            iter_lo = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_d    = res_q;
        reshi_d  = reshi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (ALUControl == OP_MUL || ALUControl == OP_DIVU) begin
                        state_d  = S_BUSY;
                        cnt_d    = CNT_W'(WIDTH);
                        is_div_d = (ALUControl == OP_DIVU);
                        opb_d    = SrcB;
                        hi_d     = '0;
                        lo_d     = SrcA;
                    end else begin
                        state_d = S_DONE;
                        res_d   = single_res;
                        reshi_d = '0;
                        zero_d  = (single_res == '0);
                        ovf_d   = single_ovf;
                        dbz_d   = 1'b0;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                hi_d  = iter_hi;
                lo_d  = iter_lo;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    res_d   = iter_lo;
                    reshi_d = iter_hi;
                    zero_d  = (iter_lo == '0);
                    ovf_d   = 1'b0;
                    dbz_d   = is_div_q && (opb_q == '0);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_q    <= '0;
            reshi_q  <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_q    <= res_d;
            reshi_q  <= reshi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign ALUResult = res_q;
    assign ResultHi  = reshi_q;
    assign Zero      = zero_q;
    assign Overflow  = ovf_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - directed and randomized checks of alu_mdu against an arithmetic reference model
module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic [2:0]  ALUControl = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] ALUResult;
    logic [31:0] ResultHi;
    logic        Zero;
    logic        Overflow;
    logic        DivByZero;

    int vectors = 0;
    int miscompares = 0;

    alu_mdu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .ResultHi(ResultHi),
        .Zero(Zero), .Overflow(Overflow), .DivByZero(DivByZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's meaning.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] lo, output logic [31:0] hi,
                         output logic z, output logic o, output logic d);
        longint      s;
        logic [63:0] p;
        lo = '0; hi = '0; o = 1'b0; d = 1'b0;
        case (op)
            3'b010: begin
                s  = longint'($signed(a)) + longint'($signed(b));
                lo = a + b;
                o  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b110: begin
                s  = longint'($signed(a)) - longint'($signed(b));
                lo = a - b;
                o  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b000: lo = a & b;
            3'b001: lo = a | b;
            3'b100: lo = ~(a | b);
            3'b111: lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011: begin
                p  = {32'd0, a} * {32'd0, b};
                lo = p[31:0];
                hi = p[63:32];
            end
            default: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF; hi = a; d = 1'b1;
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
        z = (lo == 0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] elo, ehi;
        logic        ez, eo, ed;
        int          edges, busy_bad;
        model(op, a, b, elo, ehi, ez, eo, ed);
        @(negedge clk);
        in_valid = 1'b1; ALUControl = op; SrcA = a; SrcB = b; out_ready = 1'b0;
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; SrcA = $urandom; SrcB = $urandom; ALUControl = 3'($urandom);
        @(negedge clk);
        edges = 1;
        busy_bad = 0;
        while (!out_valid && edges < 100) begin
            if (in_ready !== 1'b0) busy_bad++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, " latency"}, 64'(edges), (op == 3'b011 || op == 3'b101) ? 64'd33 : 64'd1);
        check({tag, " busy in_ready"}, 64'(busy_bad), 64'd0);
        check({tag, " ALUResult"}, 64'(ALUResult), 64'(elo));
        check({tag, " ResultHi"}, 64'(ResultHi), 64'(ehi));
        check({tag, " Zero"}, 64'(Zero), 64'(ez));
        check({tag, " Overflow"}, 64'(Overflow), 64'(eo));
        check({tag, " DivByZero"}, 64'(DivByZero), 64'(ed));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " released"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", {ALUResult, ResultHi}, 64'd0);
        check("reset flags", 64'({in_ready, out_valid, Zero, Overflow, DivByZero}), 64'b10000);
        @(negedge clk);
        reset = 1'b0;

        run_op("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'd1);
        run_op("sub_zero", 3'b110, 32'd5, 32'd5);
        run_op("slt_neg", 3'b111, 32'hFFFF_FFFF, 32'd1);
        run_op("nor_zero", 3'b100, 32'd0, 32'd0);
        run_op("mul_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("divu_100_7", 3'b101, 32'd100, 32'd7);
        run_op("divu_by_0", 3'b101, 32'd100, 32'd0);
        run_op("sub_ovf", 3'b110, 32'h8000_0000, 32'd1);
        run_op("and", 3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF);
        run_op("or", 3'b001, 32'hF000_0000, 32'h0000_000F);
        run_op("slt_eq", 3'b111, 32'd9, 32'd9);

        // Backpressure: result must hold and the waiting op must not be taken until IDLE.
        @(negedge clk);
        in_valid = 1'b1; ALUControl = 3'b010; SrcA = 32'd40; SrcB = 32'd2;
        @(posedge clk);
        #1;
        ALUControl = 3'b110; SrcA = 32'd9; SrcB = 32'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp held result", 64'(ALUResult), 64'd42);
            check("bp no accept", 64'({out_valid, in_ready}), 64'b10);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp idle after handshake", 64'({out_valid, in_ready}), 64'b01);
        check("bp result kept", 64'(ALUResult), 64'd42);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp new op done", 64'(out_valid), 64'd1);
        check("bp new op result", 64'(ALUResult), 64'd5);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset in the middle of a multiply.
        run_op("pre_reset", 3'b011, 32'd7, 32'h1_0001);
        @(negedge clk);
        in_valid = 1'b1; ALUControl = 3'b011; SrcA = 32'h1234_5678; SrcB = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("mid-mul busy", 64'({out_valid, in_ready}), 64'b00);
        reset = 1'b1;
        #1;
        check("async reset data", {ALUResult, ResultHi}, 64'd0);
        check("async reset flags", 64'({in_ready, out_valid, Zero, Overflow, DivByZero}), 64'b10000);
        @(negedge clk);
        reset = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (out_valid !== 1'b0) seen++;
            end
            check("no pulse after reset", 64'(seen), 64'd0);
        end
        run_op("add_after_reset", 3'b010, 32'd2, 32'd3);

        for (int n = 0; n < 24; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (n % 4 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if (n % 3 == 0) ra = {ra[31], ra[31:1]};
            run_op($sformatf("rand%0d_op%0d", n, rop), rop, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
